// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer.
package pc_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DISP_W_DEF = 8;

    typedef enum logic [1:0] {
        SRC_INC,
        SRC_BR,
        SRC_JMP,
        SRC_RET
    } pc_src_e;

endpackage : pc_pkg

// File: rtl/pc_sequencer_if.sv
// Decode-control / fetch-address bundle between the decoder and pc_sequencer.
interface pc_sequencer_if import pc_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DISP_W = DISP_W_DEF
);

    logic              en;
    logic              jump;
    logic              call;
    logic              ret;
    logic              branch;
    logic [ADDR_W-1:0] rdest;
    logic [DISP_W-1:0] disp;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output en, jump, call, ret, branch, rdest, disp,
        input  pc, next_pc, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  en, jump, call, ret, branch, rdest, disp,
        output pc, next_pc, ras_empty, ras_full, ras_ovf, ras_unf
    );

endinterface : pc_sequencer_if

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DATA_W-1:0]      din_i,
    output logic [DATA_W-1:0]      top_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  tos_q, tos_d, wr_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_en;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[tos_q];
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    // Push/pop/swap next-state; swap on an empty stack degrades to a push.
    always_comb begin
        tos_d  = tos_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_ptr = tos_q;
        if (push_i && pop_i) begin
            wr_en = 1'b1;
            if (empty_o) begin
                tos_d  = tos_q + PTR_W'(1);
                wr_ptr = tos_q + PTR_W'(1);
                cnt_d  = CNT_W'(1);
                unf_d  = 1'b1;
            end
        end else if (push_i) begin
            wr_en  = 1'b1;
            tos_d  = tos_q + PTR_W'(1);
            wr_ptr = tos_q + PTR_W'(1);
            if (full_o) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
            end else begin
                tos_d = tos_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage needs no reset: slots are only read once count covers them.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= din_i;
    end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with next-address selection and return-address stack.
module pc_sequencer import pc_pkg::*; #(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter int unsigned       DISP_W    = DISP_W_DEF,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, disp_ext, ras_top;
    logic [CNT_W-1:0]  ras_cnt;
    logic              ras_full, ras_empty, ras_ovf, ras_unf;
    pc_src_e           src;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign disp_ext = {{(ADDR_W-DISP_W){bus.disp[DISP_W-1]}}, bus.disp};

    // Source priority: ret > call/jump > branch > increment.
    always_comb begin
        src = SRC_INC;
        if (bus.ret)                   src = SRC_RET;
        else if (bus.call || bus.jump) src = SRC_JMP;
        else if (bus.branch)           src = SRC_BR;
    end

    always_comb begin
        pc_d = pc_inc;
        case (src)
            SRC_RET: pc_d = ras_empty ? pc_inc : ras_top;
            SRC_JMP: pc_d = bus.rdest;
            SRC_BR:  pc_d = pc_q + disp_ext;
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    pc_q <= RESET_VEC;
        else if (bus.en) pc_q <= pc_d;
    end

    pc_ras #(
        .DEPTH  (RAS_DEPTH),
        .DATA_W (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (bus.en && bus.call),
        .pop_i   (bus.en && bus.ret),
        .din_i   (pc_inc),
        .top_o   (ras_top),
        .count_o (ras_cnt),
        .full_o  (ras_full),
        .empty_o (ras_empty),
        .ovf_o   (ras_ovf),
        .unf_o   (ras_unf)
    );

    assign bus.pc        = pc_q;
    assign bus.next_pc   = pc_d;
    assign bus.ras_empty = (ras_cnt == '0);
    assign bus.ras_full  = ras_full;
    assign bus.ras_ovf   = ras_ovf;
    assign bus.ras_unf   = ras_unf;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (ADDR_W=16, DISP_W=8, RAS_DEPTH=4).
module tb_pc_sequencer;

    typedef struct {
        logic        en, jump, call, ret, branch;
        logic [15:0] rdest;
        logic [7:0]  disp;
        logic [15:0] npc, pc;
        logic        empty, full, ovf, unf;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    pc_sequencer_if #(.ADDR_W(16), .DISP_W(8)) bus_if ();

    pc_sequencer #(
        .ADDR_W    (16),
        .DISP_W    (8),
        .RAS_DEPTH (4),
        .RESET_VEC (16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic j, input logic c, input logic r,
                       input logic b, input logic [15:0] rd, input logic [7:0] d,
                       input logic [15:0] npc, input logic [15:0] pc,
                       input logic e, input logic f, input logic o, input logic u);
        vec_t v;
        v.en = en; v.jump = j; v.call = c; v.ret = r; v.branch = b;
        v.rdest = rd; v.disp = d; v.npc = npc; v.pc = pc;
        v.empty = e; v.full = f; v.ovf = o; v.unf = u;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic j, input logic c, input logic r,
                         input logic b, input logic [15:0] rd, input logic [7:0] d);
        bus_if.en = en; bus_if.jump = j; bus_if.call = c; bus_if.ret = r;
        bus_if.branch = b; bus_if.rdest = rd; bus_if.disp = d;
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f,
                               input logic o, input logic u);
        check({tag, "_empty"}, 16'(bus_if.ras_empty), 16'(e));
        check({tag, "_full"},  16'(bus_if.ras_full),  16'(f));
        check({tag, "_ovf"},   16'(bus_if.ras_ovf),   16'(o));
        check({tag, "_unf"},   16'(bus_if.ras_unf),   16'(u));
    endtask

    initial begin
        //  en j c r b rdest    disp   next_pc  pc       e f o u
        add(1, 0,0,0,0, 16'h0000, 8'h00, 16'h0001, 16'h0001, 1,0,0,0);
        add(1, 0,0,0,0, 16'h0000, 8'h00, 16'h0002, 16'h0002, 1,0,0,0);
        add(1, 0,0,0,0, 16'h0000, 8'h00, 16'h0003, 16'h0003, 1,0,0,0);
        add(0, 0,0,0,0, 16'h0000, 8'h00, 16'h0004, 16'h0003, 1,0,0,0);
        add(0, 1,0,0,0, 16'h1234, 8'h00, 16'h1234, 16'h0003, 1,0,0,0);
        add(1, 1,0,0,0, 16'h0010, 8'h00, 16'h0010, 16'h0010, 1,0,0,0);
        add(1, 0,0,0,1, 16'h0000, 8'hFC, 16'h000C, 16'h000C, 1,0,0,0);
        add(1, 0,0,0,1, 16'h0000, 8'h7F, 16'h008B, 16'h008B, 1,0,0,0);
        add(1, 1,0,0,0, 16'hFFFF, 8'h00, 16'hFFFF, 16'hFFFF, 1,0,0,0);
        add(1, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1,0,0,0);
        add(1, 1,0,0,0, 16'h0020, 8'h00, 16'h0020, 16'h0020, 1,0,0,0);
        add(1, 0,1,0,0, 16'h0100, 8'h00, 16'h0100, 16'h0100, 0,0,0,0);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0021, 16'h0021, 1,0,0,0);
        add(1, 1,0,0,0, 16'h0001, 8'h00, 16'h0001, 16'h0001, 1,0,0,0);
        add(1, 0,1,0,0, 16'h0011, 8'h00, 16'h0011, 16'h0011, 0,0,0,0);
        add(1, 0,1,0,0, 16'h0021, 8'h00, 16'h0021, 16'h0021, 0,0,0,0);
        add(1, 0,1,0,0, 16'h0031, 8'h00, 16'h0031, 16'h0031, 0,0,0,0);
        add(1, 0,1,0,0, 16'h0041, 8'h00, 16'h0041, 16'h0041, 0,1,0,0);
        add(1, 0,1,0,0, 16'h0051, 8'h00, 16'h0051, 16'h0051, 0,1,1,0);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0042, 16'h0042, 0,0,1,0);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0032, 16'h0032, 0,0,1,0);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0022, 16'h0022, 0,0,1,0);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0012, 16'h0012, 1,0,1,0);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0013, 16'h0013, 1,0,1,1);
        add(1, 1,0,0,0, 16'h004F, 8'h00, 16'h004F, 16'h004F, 1,0,1,1);
        add(1, 0,1,0,0, 16'h004F, 8'h00, 16'h004F, 16'h004F, 0,0,1,1);
        add(1, 0,1,0,0, 16'h004F, 8'h00, 16'h004F, 16'h004F, 0,0,1,1);
        add(1, 1,0,1,1, 16'h1234, 8'h04, 16'h0050, 16'h0050, 0,0,1,1);
        add(1, 1,0,0,0, 16'h0060, 8'h00, 16'h0060, 16'h0060, 0,0,1,1);
        add(1, 0,1,1,0, 16'h0200, 8'h00, 16'h0050, 16'h0050, 0,0,1,1);
        add(1, 0,0,1,0, 16'h0000, 8'h00, 16'h0061, 16'h0061, 1,0,1,1);
        add(0, 0,0,1,0, 16'h0000, 8'h00, 16'h0062, 16'h0061, 1,0,1,1);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", bus_if.pc, 16'h0000);
        check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].jump, vecs[i].call, vecs[i].ret,
                  vecs[i].branch, vecs[i].rdest, vecs[i].disp);
            #1;
            check($sformatf("r%0d_npc", i), bus_if.next_pc, vecs[i].npc);
            @(posedge clk);
            #1;
            check($sformatf("r%0d_pc", i), bus_if.pc, vecs[i].pc);
            check_flags($sformatf("r%0d", i), vecs[i].empty, vecs[i].full,
                        vecs[i].ovf, vecs[i].unf);
        end

        // Asynchronous reset asserted in the low phase while a call is pending.
        drive(1, 0, 1, 0, 0, 16'h0400, 8'h00);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_pc", bus_if.pc, 16'h0000);
        check_flags("async", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 16'h0000, 8'h00);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_pc", bus_if.pc, 16'h0000);

        // Swap on an empty stack: behaves as push of pc+1 and flags underflow.
        drive(1, 0, 1, 1, 0, 16'h0300, 8'h00);
        #1;
        check("swap_e_npc", bus_if.next_pc, 16'h0001);
        @(posedge clk);
        #1;
        check("swap_e_pc", bus_if.pc, 16'h0001);
        check_flags("swap_e", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1, 0, 0, 1, 0, 16'h0000, 8'h00);
        @(posedge clk);
        #1;
        check("swap_e_ret_pc", bus_if.pc, 16'h0001);
        check_flags("swap_e_ret", 1'b1, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_sequencer
